// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: widths, load-op encodings and
// the MEM->WB pipeline register layout.
package wb_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RF_AW = 5;

  // Load-op encodings from MEM; 5..7 are reserved and behave as ld.w.
  typedef enum logic [2:0] {
    LdW  = 3'd0,
    LdB  = 3'd1,
    LdH  = 3'd2,
    LdBu = 3'd3,
    LdHu = 3'd4
  } ld_op_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic             gr_we;
    logic [RF_AW-1:0] dest;
    logic             res_from_mem;
    logic [2:0]       ld_op;
    logic [1:0]       addr_lo;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  mem_rdata;
  } ws_bus_t;

endpackage

// File: rtl/wb_stage_ld_align.sv
// Load data alignment: selects the addressed byte/half from the raw SRAM word
// and sign- or zero-extends it according to the load op.
module wb_stage_ld_align
  import wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      ld_op,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    value = rdata;
    case (ld_op)
      LdB:     value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LdBu:    value = {{(XLEN-8){1'b0}}, byte_sel};
      LdH:     value = {{(XLEN-16){half_sel[15]}}, half_sel};
      LdHu:    value = {{(XLEN-16){1'b0}}, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM->WB pipeline register, regfile write port and difftest trace.
// Define WB_FWD_EN to export the forwarding/hazard bus to decode.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ms_to_ws_valid,
  output logic             ws_allowin,
  input  logic [XLEN-1:0]  ms_pc,
  input  logic             ms_gr_we,
  input  logic [RF_AW-1:0] ms_dest,
  input  logic             ms_res_from_mem,
  input  logic [2:0]       ms_ld_op,
  input  logic [1:0]       ms_addr_lo,
  input  logic [XLEN-1:0]  ms_result,
  input  logic [XLEN-1:0]  ms_mem_rdata,
  input  logic             ws_stall,
  input  logic             ws_flush,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
`ifdef WB_FWD_EN
  output logic             ws_fwd_valid,
  output logic [RF_AW-1:0] ws_fwd_dest,
  output logic [XLEN-1:0]  ws_fwd_data,
`endif
  output logic [XLEN-1:0]  debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [RF_AW-1:0] debug_wb_rf_wnum,
  output logic [XLEN-1:0]  debug_wb_rf_wdata
);

  logic    ws_valid_q, ws_valid_d;
  ws_bus_t ws_q, ws_d;
  logic    ws_ready_go;
  logic    dest_nz;
  logic [XLEN-1:0] ld_value;

  assign ws_ready_go = ~ws_stall;
  assign ws_allowin  = ~ws_valid_q | ws_ready_go;

  // A capture replaces the held instruction, so it takes priority over flush.
  always_comb begin
    ws_valid_d = ws_valid_q;
    ws_d       = ws_q;
    if (ms_to_ws_valid && ws_allowin) begin
      ws_valid_d         = 1'b1;
      ws_d.pc            = ms_pc;
      ws_d.gr_we         = ms_gr_we;
      ws_d.dest          = ms_dest;
      ws_d.res_from_mem  = ms_res_from_mem;
      ws_d.ld_op         = ms_ld_op;
      ws_d.addr_lo       = ms_addr_lo;
      ws_d.result        = ms_result;
      ws_d.mem_rdata     = ms_mem_rdata;
    end else if (ws_ready_go || ws_flush) begin
      ws_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      ws_q       <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      ws_q       <= ws_d;
    end
  end

  wb_stage_ld_align u_ld_align (
    .rdata   (ws_q.mem_rdata),
    .addr_lo (ws_q.addr_lo),
    .ld_op   (ws_q.ld_op),
    .value   (ld_value)
  );

  assign dest_nz = |ws_q.dest;

  // Write strobes only on the unstalled cycle, so each instruction retires once.
  always_comb begin
    rf_we    = ws_valid_q & ws_ready_go & ~ws_flush & ws_q.gr_we & dest_nz;
    rf_waddr = ws_q.dest;
    rf_wdata = ws_q.res_from_mem ? ld_value : ws_q.result;
  end

  assign debug_wb_pc       = ws_q.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

`ifdef WB_FWD_EN
  // Asserted while stalled too, so decode can bypass the pending write.
  assign ws_fwd_valid = ws_valid_q & ws_q.gr_we & dest_nz;
  assign ws_fwd_dest  = ws_q.dest;
  assign ws_fwd_data  = rf_wdata;
`endif

endmodule
